dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the 5-stage MIPS pipeline. The M stage issues load/store requests as initiator; this block accepts one request at a time, models a fixed access latency, and returns read data or a write acknowledge. While a request is outstanding it drives `stall` back to the hazard/stall logic, which freezes the IF, D, X and M stages.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width, matching the 8-bit `ProgramCounter` width.
- `DEPTH`, 256: number of 32-bit words implemented, at most 2^ADDR_W.
- `LATENCY`, 2: cycles from accept to response, legal range 1..15.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: M stage holds a load or store.
- `req_write` in 1: 1 means store, 0 means load.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in 32: store data.
- `req_ready` out 1: block can accept a request this cycle.
- `resp_valid` out 1: one-cycle pulse when the access completes.
- `resp_write` out 1: qualifies `resp_valid`; 1 means store acknowledge.
- `resp_rdata` out 32: load data, valid with `resp_valid` and `resp_write`=0.
- `resp_err` out 1: the address was `>= DEPTH`; valid with `resp_valid`.
- `stall` out 1: pipeline stall request.

## Operation
- FSM states: IDLE, BUSY, RESP. 4-bit down-counter `cnt`.
- IDLE:
  - `req_ready`=1.
  - When `req_valid`=1, the request is accepted: `req_write`, `req_addr` and `req_wdata` are latched, `cnt` is loaded with LATENCY-1, and the FSM goes to BUSY.
- BUSY:
  - If `cnt`!=0, decrement.
  - If `cnt`==0, go to RESP at the edge. At that same edge:
    - A store writes the array, unless the address is out of range.
    - A load samples the array into the `resp_rdata` register.
    - `resp_err` is registered.
- RESP:
  - `resp_valid`=1 for exactly one cycle. `resp_write` equals the latched `req_write`.
  - Go unconditionally to IDLE. A request is never accepted in RESP.
- Request inputs are ignored outside the accept cycle. Changes to them during BUSY have no effect.
- `stall` = (IDLE & `req_valid`) | BUSY. It is combinational from `req_valid` in IDLE and 0 in RESP, which lets the pipeline advance past the completed access.
- Out-of-range access (`req_addr >= DEPTH`):
  - A store is dropped and the array is unchanged.
  - A load returns `resp_rdata`=0.
  - `resp_err`=1 in both cases. Timing is identical to an in-range access.
- `resp_rdata` holds its last value until the next load completes. Store responses leave it unchanged.
- Read-after-write: a load accepted after a store's RESP cycle returns the stored value. There is no internal bypass, because only one access is outstanding at a time.
- Array contents are not reset. Only control and output registers are reset.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM goes to IDLE, `cnt`=0.
  - Outputs: `resp_valid`=0, `resp_write`=0, `resp_rdata`=0, `resp_err`=0, `req_ready`=1.
  - `stall` equals `req_valid`.
- Accept occurs at edge E0. RESP is entered at edge E0+LATENCY, so `resp_valid` is high during cycle E0+LATENCY .. E0+LATENCY+1.
- Throughput: one request per LATENCY+2 cycles when the next request is held continuously.
- `stall` is high from the cycle `req_valid` rises in IDLE through the last BUSY cycle: LATENCY+1 cycles in total.
- Reset mid-BUSY aborts the access:
  - A pending store is not written.
  - No `resp_valid` is issued.
  - After `rst` is released the FSM is in IDLE.
- Reset asserted during RESP forces `resp_valid` low immediately.
- LATENCY=1: BUSY lasts one cycle with `cnt`=0, giving accept, BUSY, RESP.

## Test plan
- Reset, then store 0xDEADBEEF to address 0x10 with LATENCY=2 -> `stall` high 3 cycles; at E0+2, `resp_valid`=1, `resp_write`=1, `resp_err`=0.
- Then load address 0x10 -> at E0+2, `resp_valid`=1, `resp_write`=0, `resp_rdata`=0xDEADBEEF. Then store to 0x11 -> `resp_rdata` stays 0xDEADBEEF.
- Hold `req_valid` through store 0x20=0x1, then load 0x20 -> requests accepted 4 cycles apart; load returns 0x1; `req_ready`=0 in BUSY and RESP.
- Change `req_addr`/`req_wdata` during BUSY of a store to 0x05=0xA5 -> only 0x05 is written, with 0xA5; a later load confirms it.
- With DEPTH=128: store 0x1234 to 0x90, then load 0x90 -> `resp_err`=1 both times, `resp_rdata`=0; load 0x10 (after prior contents written) is unchanged.
- Store to 0x30=0x55 completes; store 0x30=0xFF, with `rst` pulsed low in its BUSY -> no `resp_valid`; outputs return to reset values; later load of 0x30 returns 0x55.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the M-stage initiator and the data-memory responder.
`timescale 1ns/1ps
interface dmem_responder_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_write;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_write, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_write, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Stalls the pipeline from request until the response cycle.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic              rd_sel_q, rd_sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       mem_rd_q;
    logic              in_range;
    logic              finish;
    logic [IDX_W-1:0]  mem_idx;

    assign in_range = 32'(addr_q) < 32'(DEPTH);
    assign finish   = (state_q == BUSY) && (cnt_q == 4'd0);
    assign mem_idx  = addr_q[IDX_W-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        err_d    = err_q;
        rd_sel_d = rd_sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    err_d   = !in_range;
                    // Out-of-range loads read as zero; stores leave the read data alone.
                    if (!write_q) begin
                        rd_sel_d = in_range;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            err_q    <= err_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Single-port array: one write or one registered read per completed access.
    always_ff @(posedge clk) begin
        if (finish && in_range) begin
            if (write_q) begin
                mem[mem_idx] <= wdata_q;
            end else begin
                mem_rd_q <= mem[mem_idx];
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_write = write_q;
    assign bus.resp_rdata = rd_sel_q ? mem_rd_q : 32'd0;
    assign bus.resp_err   = err_q;
    assign bus.stall      = ((state_q == IDLE) && bus.req_valid) || (state_q == BUSY);
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus reset/back-to-back sequences.
`timescale 1ns/1ps
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(8)) bus ();
    dmem_responder_if #(.ADDR_W(8)) bus1 ();

    dmem_responder #(.ADDR_W(8), .DEPTH(128), .LATENCY(2)) dut (
        .clk(clk), .rst(rst_n), .bus(bus.slave)
    );
    dmem_responder #(.ADDR_W(8), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst_n), .bus(bus1.slave)
    );

    typedef struct {
        logic        w;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   tests = 0;
    int   fails = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Scoreboard: every response must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                e = sb.pop_front();
                check("resp_write", 32'(bus.resp_write), 32'(e.w));
                check("resp_err", 32'(bus.resp_err), 32'(e.err));
                check("resp_rdata", bus.resp_rdata, e.rdata);
                $display("[TB] resp write=%0d err=%0d rdata=0x%08h", bus.resp_write, bus.resp_err, bus.resp_rdata);
            end
        end
    end

    // Drive a request at the current negedge; accept happens at the next posedge.
    task automatic drive(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        #1;
        check("stall_on_valid", 32'(bus.stall), 32'd1);
        check("ready_idle", 32'(bus.req_ready), 32'd1);
        sb.push_back('{w, er, ee});
    endtask

    // Drop the request, scramble the inputs, and wait (bounded) for the response.
    task automatic wait_resp(input logic w, input logic [7:0] a, input logic [31:0] d);
        int k;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_addr  = ~a;
        bus.req_wdata = ~d;
        k = 1;
        while (bus.resp_valid !== 1'b1 && k <= 20) begin
            check("stall_busy", 32'(bus.stall), 32'd1);
            check("ready_busy", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'd3);
        check("stall_resp", 32'(bus.stall), 32'd0);
        check("ready_resp", 32'(bus.req_ready), 32'd0);
        $display("[TB] req w=%0d addr=0x%02h wdata=0x%08h edges_to_resp=%0d", w, a, d, k);
    endtask

    task automatic run_req(input logic w, input logic [7:0] a, input logic [31:0] d,
                           input logic [31:0] er, input logic ee);
        @(negedge clk);
        drive(w, a, d, er, ee);
        wait_resp(w, a, d);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 8'h00;
        bus.req_wdata  = 32'h0;
        bus1.req_valid = 1'b0;
        bus1.req_write = 1'b0;
        bus1.req_addr  = 8'h00;
        bus1.req_wdata = 32'h0;

        vecs[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 8'h11, 32'h12345678, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 8'h11, 32'h0,        32'h12345678, 1'b0};
        vecs[4]  = '{1'b1, 8'h90, 32'h00001234, 32'h12345678, 1'b1};
        vecs[5]  = '{1'b0, 8'h90, 32'h0,        32'h00000000, 1'b1};
        vecs[6]  = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 8'h06, 32'h00000066, 32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 8'h05, 32'h000000A5, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b0, 8'h05, 32'h0,        32'h000000A5, 1'b0};
        vecs[10] = '{1'b0, 8'h06, 32'h0,        32'h00000066, 1'b0};
        vecs[11] = '{1'b1, 8'h7F, 32'hCAFEF00D, 32'h00000066, 1'b0};
        vecs[12] = '{1'b0, 8'h7F, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[13] = '{1'b0, 8'h80, 32'h0,        32'h00000000, 1'b1};

        // Reset state
        #1;
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_write", 32'(bus.resp_write), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_stall_lo", 32'(bus.stall), 32'd0);
        bus.req_valid = 1'b1;
        #1;
        check("rst_stall_hi", 32'(bus.stall), 32'd1);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].er, vecs[i].ee);
        end

        // Back-to-back with req_valid held: accepts 4 cycles apart
        @(negedge clk);
        drive(1'b1, 8'h20, 32'h1, 32'h0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("b2b_ready", 32'(bus.req_ready), (i == 4) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 8'h20, 32'h0, 32'h1, 1'b0);
        wait_resp(1'b0, 8'h20, 32'h0);

        // Reset in BUSY aborts a store
        run_req(1'b1, 8'h30, 32'h55, 32'h1, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h30;
        bus.req_wdata = 32'hFF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_resp_write", 32'(bus.resp_write), 32'd0);
        check("abort_resp_rdata", bus.resp_rdata, 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_stall", 32'(bus.stall), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("abort_idle", 32'(bus.req_ready), 32'd1);
        run_req(1'b0, 8'h30, 32'h0, 32'h55, 1'b0);

        // Reset during RESP drops resp_valid at once
        run_req(1'b1, 8'h31, 32'h9, 32'h55, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("resp_rst_valid", 32'(bus.resp_valid), 32'd0);
        check("resp_rst_rdata", bus.resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b0, 8'h31, 32'h0, 32'h9, 1'b0);

        // LATENCY=1 instance: accept, one BUSY cycle, RESP
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus1.req_valid = 1'b1;
            bus1.req_write = (i == 0);
            bus1.req_addr  = 8'h03;
            bus1.req_wdata = 32'h77;
            @(negedge clk);
            bus1.req_valid = 1'b0;
            bus1.req_wdata = 32'h0;
            check("l1_busy_valid", 32'(bus1.resp_valid), 32'd0);
            check("l1_busy_stall", 32'(bus1.stall), 32'd1);
            @(negedge clk);
            check("l1_resp_valid", 32'(bus1.resp_valid), 32'd1);
            check("l1_resp_write", 32'(bus1.resp_write), (i == 0) ? 32'd1 : 32'd0);
            check("l1_resp_rdata", bus1.resp_rdata, (i == 0) ? 32'd0 : 32'h77);
            $display("[TB] lat1 op=%0d resp_valid=%0d rdata=0x%08h", i, bus1.resp_valid, bus1.resp_rdata);
        end

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
